// File: rtl/zedboard_to_video.sv
// zedboard_to_video: rebuilds a 24-bit 4:4:4 vid_io stream from the ZedBoard
// 16-bit YCbCr 4:2:2 HDMI pin bus, and measures frame geometry and lock.
// Three register stages: s1 (pin capture), s2 (chroma pairing), s3 (outputs).
module zedboard_to_video #(
    parameter int SYNC_ACTIVE_HIGH = 1,
    parameter int LOCK_FRAMES      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        HD_DE,
    input  logic [15:0] HD_D,
    input  logic        HD_HSYNC,
    input  logic        HD_VSYNC,
    output logic        vid_io_out_active_video,
    output logic [23:0] vid_io_out_data,
    output logic        vid_io_out_field,
    output logic        vid_io_out_hblank,
    output logic        vid_io_out_vblank,
    output logic        vid_io_out_hsync,
    output logic        vid_io_out_vsync,
    output logic [11:0] frame_width,
    output logic [11:0] frame_height,
    output logic        locked
);

    localparam logic        SYNC_POL = (SYNC_ACTIVE_HIGH != 0);
    localparam logic [3:0]  LOCK_TH  = 4'(LOCK_FRAMES);
    localparam logic [11:0] CNT_MAX  = 12'hFFF;

    // Syncs are held active-high internally and re-polarised at the outputs.
    logic        s1_de, s1_hs, s1_vs;
    logic [15:0] s1_d;
    logic        s2_de, s2_hs, s2_vs, s2_odd, s2_vb;
    logic [15:0] s2_d;
    logic        s3_vs;
    logic        de_seen;
    logic [7:0]  cb_hold;
    logic [11:0] pix_cnt, line_cnt;
    logic [3:0]  match_cnt;
    logic        armed;

    logic        s1_odd, hs_edge, vb_next;
    logic        de_rise, vs_edge, geom_same;
    logic [3:0]  match_next;
    logic [23:0] pix_data;

    // Chroma phase, vblank decision and 4:2:2 -> 4:4:4 pairing.
    // An even pixel in s2 borrows Cr from the odd pixel behind it in s1;
    // an odd pixel reuses the Cb saved from its even partner.
    always_comb begin
        s1_odd  = s2_de & ~s2_odd;
        hs_edge = s1_hs & ~s2_hs;
        if (s1_de)
            vb_next = 1'b0;
        else if (hs_edge && !de_seen)
            vb_next = 1'b1;
        else
            vb_next = s2_vb;
        if (!s2_de)
            pix_data = 24'h0;
        else if (s2_odd)
            pix_data = {s2_d[7:0], cb_hold, s2_d[15:8]};
        else
            pix_data = {(s1_de ? s1_d[7:0] : 8'h80), s2_d[7:0], s2_d[15:8]};
    end

    // Measurement runs on the s2 stage so latched results land together
    // with the output vsync leading edge.
    always_comb begin
        de_rise    = s2_de & ~vid_io_out_active_video;
        vs_edge    = s2_vs & ~s3_vs;
        geom_same  = (pix_cnt == frame_width) && (line_cnt == frame_height) &&
                     (pix_cnt != 12'd0) && (line_cnt != 12'd0);
        if (!geom_same)
            match_next = 4'd0;
        else if (match_cnt == 4'hF)
            match_next = 4'hF;
        else
            match_next = match_cnt + 4'd1;
    end

    // Video pipeline: capture, pairing and aligned output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_de                   <= 1'b0;
            s1_d                    <= 16'h0;
            s1_hs                   <= 1'b0;
            s1_vs                   <= 1'b0;
            s2_de                   <= 1'b0;
            s2_d                    <= 16'h0;
            s2_hs                   <= 1'b0;
            s2_vs                   <= 1'b0;
            s2_odd                  <= 1'b0;
            s2_vb                   <= 1'b1;
            s3_vs                   <= 1'b0;
            de_seen                 <= 1'b0;
            cb_hold                 <= 8'h0;
            vid_io_out_active_video <= 1'b0;
            vid_io_out_data         <= 24'h0;
            vid_io_out_hblank       <= 1'b1;
            vid_io_out_vblank       <= 1'b1;
            vid_io_out_hsync        <= ~SYNC_POL;
            vid_io_out_vsync        <= ~SYNC_POL;
        end else begin
            s1_de  <= HD_DE;
            s1_d   <= HD_D;
            s1_hs  <= (HD_HSYNC == SYNC_POL);
            s1_vs  <= (HD_VSYNC == SYNC_POL);
            s2_de  <= s1_de;
            s2_d   <= s1_d;
            s2_hs  <= s1_hs;
            s2_vs  <= s1_vs;
            s2_odd <= s1_odd & s1_de;
            s2_vb  <= vb_next;
            s3_vs  <= s2_vs;
            if (hs_edge)
                de_seen <= s1_de;
            else if (s1_de)
                de_seen <= 1'b1;
            if (s2_de && !s2_odd)
                cb_hold <= s2_d[7:0];
            vid_io_out_active_video <= s2_de;
            vid_io_out_data         <= pix_data;
            vid_io_out_hblank       <= ~s2_de;
            vid_io_out_vblank       <= s2_vb;
            vid_io_out_hsync        <= s2_hs ? SYNC_POL : ~SYNC_POL;
            vid_io_out_vsync        <= s2_vs ? SYNC_POL : ~SYNC_POL;
        end
    end

    // Frame size counters, latch on vsync and lock tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_cnt      <= 12'd0;
            line_cnt     <= 12'd0;
            armed        <= 1'b0;
            frame_width  <= 12'd0;
            frame_height <= 12'd0;
            match_cnt    <= 4'd0;
            locked       <= 1'b0;
        end else begin
            if (de_rise)
                pix_cnt <= 12'd1;
            else if (s2_de && pix_cnt != CNT_MAX)
                pix_cnt <= pix_cnt + 12'd1;
            if (vs_edge) begin
                line_cnt <= de_rise ? 12'd1 : 12'd0;
                armed    <= 1'b1;
                if (armed) begin
                    frame_width  <= pix_cnt;
                    frame_height <= line_cnt;
                    match_cnt    <= match_next;
                    locked       <= (match_next >= LOCK_TH);
                end
            end else if (de_rise && line_cnt != CNT_MAX) begin
                line_cnt <= line_cnt + 12'd1;
            end
        end
    end

    assign vid_io_out_field = 1'b0;

endmodule

// File: doc/zedboard_to_video.md
# zedboard_to_video

Receive-side counterpart of the ZedBoard HDMI output path. Takes the 16-bit YCbCr 4:2:2 pin bus (HD_D/HD_DE/HD_HSYNC/HD_VSYNC, Y on HD_D[15:8], alternating Cb/Cr on HD_D[7:0]) and rebuilds a 24-bit 4:4:4 vid_io stream with blanking flags. It also measures the frame size and flags a stable lock. It sits between the pin capture and any vid_io consumer, such as a video-in-to-AXI4-Stream bridge.

## Interface
Parameters:
- SYNC_ACTIVE_HIGH, 1, sync polarity on both the pins and the outputs (1 = active high, 0 = active low)
- LOCK_FRAMES, 2, number of consecutive matching frame measurements required to assert locked (1..15)

Ports:
- clk  in  1  pixel clock; all logic runs on its rising edge
- reset  in  1  synchronous, active-high reset
- HD_DE  in  1  data enable
- HD_D  in  16  [15:8] = Y, [7:0] = Cb (even pixels) or Cr (odd pixels)
- HD_HSYNC  in  1  horizontal sync
- HD_VSYNC  in  1  vertical sync
- vid_io_out_active_video  out  1  pixel valid
- vid_io_out_data  out  24  {Cr, Cb, Y}
- vid_io_out_field  out  1  constant 0 (progressive only)
- vid_io_out_hblank  out  1  horizontal blanking
- vid_io_out_vblank  out  1  vertical blanking
- vid_io_out_hsync  out  1  delayed HD_HSYNC
- vid_io_out_vsync  out  1  delayed HD_VSYNC
- frame_width  out  12  active pixels in the last active line of the previous frame
- frame_height  out  12  active lines in the previous frame
- locked  out  1  frame geometry stable

## Operation
- All pins are registered on entry (stage s1). "Leading edge" means the s1 sync transition into its active level.
- Chroma phase:
  - Cleared whenever s1 DE = 0.
  - The first DE pixel of a line is even (carries Cb); the phase toggles on each DE pixel.
- Upsampling:
  - Pixels 2k and 2k+1 both output Cb(2k) and Cr(2k+1), each with its own Y.
  - If a line has odd length, the last (even) pixel uses Cr = 0x80.
- hblank = NOT active_video.
- vblank:
  - Set on an hsync leading edge if no DE pixel occurred since the previous hsync leading edge.
  - Cleared so that output vblank falls in the same cycle as the first output active_video of the frame.
- Measurement:
  - pix_cnt counts DE pixels per line and clears on DE rising.
  - line_cnt counts lines containing at least one DE pixel.
  - Both counters saturate at 4095.
  - On a vsync leading edge, the measured width (pix_cnt of the last active line) and height (line_cnt) are latched into frame_width and frame_height, and line_cnt clears.
- Lock:
  - match_cnt increments (saturating) when the new latched pair equals the previous pair and both are nonzero. Otherwise it clears to 0.
  - locked = (match_cnt >= LOCK_FRAMES).
- After reset, measurement is disarmed until the first vsync leading edge. That edge latches nothing; it only arms measurement.
- Reset mid-line flushes the pipeline. If DE is still high after reset, the first sampled pixel is treated as even (Cb).

## Timing
- Reset values:
  - data = 0, active_video = 0, field = 0
  - hblank = 1, vblank = 1
  - hsync and vsync at the inactive level (0 if SYNC_ACTIVE_HIGH, else 1)
  - frame_width = 0, frame_height = 0, locked = 0, match_cnt = 0
- Latency: exactly 3 clk cycles from the pins to every vid_io_out signal. data, active_video, hsync, vsync and the blank flags stay mutually aligned.
- frame_width, frame_height and locked update in the same cycle that vid_io_out_vsync first shows its active level, and hold until the next such edge.
- No backpressure. One pixel is accepted per cycle whenever DE = 1.
- A DE high for one cycle is a valid 1-pixel line: its Cr = 0x80 and the measured width is 1.
- If vsync and hsync leading edges occur in the same cycle, the hsync vblank rule is evaluated first, then the vsync latch.

## Test plan
- Reset: hold reset 4 cycles with random pins → every output equals its reset value; output hsync and vsync are inactive for both SYNC_ACTIVE_HIGH settings.
- 4-pixel line, Y = 0x10..0x13, C = 0x20, 0x30, 0x40, 0x50 → 3 cycles later, data = 0x302010, 0x302011, 0x504012, 0x504013; active_video high for 4 cycles; hblank low for the same 4 cycles.
- 3-pixel line, Y = 0x01..0x03, C = 0xA0, 0xB0, 0xC0 → data = 0xB0A001, 0xB0A002, 0x80C003.
- Frame timing 8x4 repeated for 4 frames, LOCK_FRAMES = 2:
  - frame_width = 8, frame_height = 4 after the first latch.
  - locked rises at the vsync edge ending frame 3.
  - A following 6x4 frame → frame_width = 6 and locked = 0 at its closing vsync edge.
- vblank: two lines without DE, then an active line → vblank rises at the second empty line's hsync (output-aligned), and falls in the same cycle as the first active_video.
- Reset asserted mid-line while DE stays high → after release, the first output pixel carries Cb from its own sample; the next vsync only arms measurement; frame_width and frame_height are first latched at the vsync after that.
